// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Register-scoreboard hazard unit for the ID stage of the RV32 pipeline.
//   Keeps one down-counter per architectural register holding the number of
//   cycles until its in-flight write commits. Issue is held on RAW hazards
//   (a source still pending) and on WAW hazards (an older write to the same
//   destination would commit after this one). A saturating counter records
//   stalled cycles for performance tracing.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   id_valid     ID holds a valid instruction
//   id_rs/id_re  packed source addresses (port i at [i*REG_AW +: REG_AW]) and
//                their read enables
//   id_we/id_rd  destination write enable and address
//   id_lat       result latency, clamped to 1..MAX_LAT
//   flush        kill the ID instruction this cycle
//   stat_clr     synchronous clear of stall_cnt
//   issue/stall  instruction leaves / is held in ID
//   stall_raw/stall_waw  hazard type contributing to stall
//   busy         per-register pending-write flags
//   stall_cnt    saturating count of stalled cycles
module hazard_scoreboard #(
  parameter  int REG_AW  = 5,
  parameter  int NREAD   = 2,
  parameter  int MAX_LAT = 4,
  parameter  int CNT_W   = 32,
  localparam int LW      = $clog2(MAX_LAT + 1),
  localparam int NREG    = 2 ** REG_AW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [NREAD*REG_AW-1:0] id_rs,
  input  logic [NREAD-1:0]        id_re,
  input  logic                    id_we,
  input  logic [REG_AW-1:0]       id_rd,
  input  logic [LW-1:0]           id_lat,
  input  logic                    flush,
  input  logic                    stat_clr,
  output logic                    issue,
  output logic                    stall,
  output logic                    stall_raw,
  output logic                    stall_waw,
  output logic [NREG-1:0]         busy,
  output logic [CNT_W-1:0]        stall_cnt
);

  logic [LW-1:0]    cnt_q [NREG];
  logic [LW-1:0]    cnt_d [NREG];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [LW-1:0]     eff_lat;
  logic              raw, waw;
  logic [REG_AW-1:0] rs;

  // Latency clamp: 0 behaves as a single-cycle result, anything above the
  // deepest pipe behaves as MAX_LAT.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    eff_lat = id_lat;
    if (id_lat == '0)                 eff_lat = LW'(1);
    else if (id_lat > LW'(MAX_LAT))   eff_lat = LW'(MAX_LAT);
  end

  // Hazard detection uses pre-update counters, so an instruction never
  // stalls on its own destination.
  always_comb begin
    raw = 1'b0;
    rs  = '0;
    for (int i = 0; i < NREAD; i++) begin
      rs = id_rs[i*REG_AW +: REG_AW];
      if (id_re[i] && (rs != '0) && (cnt_q[rs] != '0)) raw = 1'b1;
    end
    // A pending write that commits no later than ours is harmless.
    waw = id_we && (id_rd != '0) && (cnt_q[id_rd] > eff_lat);
  end

  assign stall_raw = id_valid && !flush && raw;
  assign stall_waw = id_valid && !flush && waw;
  assign stall     = stall_raw || stall_waw;
  assign issue     = id_valid && !flush && !stall;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LW'(1) : '0;
    end
    // The load of the issuing destination overrides its decrement.
    if (issue && id_we && (id_rd != '0)) cnt_d[id_rd] = eff_lat;
    // x0 is never tracked; its flop is held at zero and optimises away.
    cnt_d[0] = '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr)                            stall_cnt_d = '0;
    else if (stall && (stall_cnt_q != '1))   stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter array is reset on purpose, unlike a data memory:
      // reset must drop every pending write so nothing stalls after release.
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) busy[r] = (cnt_q[r] != '0);
    busy[0] = 1'b0;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_re;
  logic        id_we;
  logic [4:0]  id_rd;
  logic [2:0]  id_lat;
  logic        flush;
  logic        stat_clr;

  logic        issue, stall, stall_raw, stall_waw;
  logic [31:0] busy;
  logic [31:0] stall_cnt;

  logic        s_issue, s_stall, s_raw, s_waw;
  logic [31:0] s_busy;
  logic [2:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_re(id_re),
    .id_we(id_we), .id_rd(id_rd), .id_lat(id_lat), .flush(flush), .stat_clr(stat_clr),
    .issue(issue), .stall(stall), .stall_raw(stall_raw), .stall_waw(stall_waw),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  // Narrow statistics counter instance for the saturation check.
  hazard_scoreboard #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_re(id_re),
    .id_we(id_we), .id_rd(id_rd), .id_lat(id_lat), .flush(flush), .stat_clr(stat_clr),
    .issue(s_issue), .stall(s_stall), .stall_raw(s_raw), .stall_waw(s_waw),
    .busy(s_busy), .stall_cnt(s_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [4:0]  rs0, rs1;
    logic [1:0]  re;
    logic        we;
    logic [4:0]  rd;
    logic [2:0]  lat;
    logic        fl;
    logic        clr;
    logic        e_issue, e_stall, e_raw, e_waw;
    logic [31:0] e_busy;
    logic [31:0] e_scnt;
  } vec_t;

  function automatic vec_t mk(
    input logic valid, input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] re,
    input logic we, input logic [4:0] rd, input logic [2:0] lat, input logic fl, input logic clr,
    input logic ei, input logic es, input logic er, input logic ew,
    input logic [31:0] eb, input logic [31:0] ec);
    vec_t v;
    v.valid = valid; v.rs0 = rs0; v.rs1 = rs1; v.re = re; v.we = we; v.rd = rd;
    v.lat = lat; v.fl = fl; v.clr = clr; v.e_issue = ei; v.e_stall = es;
    v.e_raw = er; v.e_waw = ew; v.e_busy = eb; v.e_scnt = ec;
    return v;
  endfunction

  task automatic drive(input logic valid, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] re, input logic we, input logic [4:0] rd,
                       input logic [2:0] lat, input logic fl, input logic clr);
    id_valid = valid; id_rs = {rs1, rs0}; id_re = re; id_we = we; id_rd = rd;
    id_lat = lat; flush = fl; stat_clr = clr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  int   nstall;

  initial begin
    // Back-to-back RAW: x5 lat 3, dependent held for 3 cycles.
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 5, 3, 0, 0,  1, 0, 0, 0, 32'h0,   0));
    vecs.push_back(mk(1, 5, 1, 2'b11, 1, 6, 1, 0, 0,  0, 1, 1, 0, 32'h20,  0));
    vecs.push_back(mk(1, 5, 1, 2'b11, 1, 6, 1, 0, 0,  0, 1, 1, 0, 32'h20,  1));
    vecs.push_back(mk(1, 5, 1, 2'b11, 1, 6, 1, 0, 0,  0, 1, 1, 0, 32'h20,  2));
    vecs.push_back(mk(1, 5, 1, 2'b11, 1, 6, 1, 0, 0,  1, 0, 0, 0, 32'h0,   3));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0,  0, 0, 0, 0, 32'h40,  3));
    // Load-use on port 1, x7 lat 4.
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 7, 4, 0, 0,  1, 0, 0, 0, 32'h0,   3));
    vecs.push_back(mk(1, 2, 7, 2'b11, 0, 0, 1, 0, 0,  0, 1, 1, 0, 32'h80,  3));
    vecs.push_back(mk(1, 2, 7, 2'b11, 0, 0, 1, 0, 0,  0, 1, 1, 0, 32'h80,  4));
    vecs.push_back(mk(1, 2, 7, 2'b11, 0, 0, 1, 0, 0,  0, 1, 1, 0, 32'h80,  5));
    vecs.push_back(mk(1, 2, 7, 2'b11, 0, 0, 1, 0, 0,  0, 1, 1, 0, 32'h80,  6));
    vecs.push_back(mk(1, 2, 7, 2'b11, 0, 0, 1, 0, 0,  1, 0, 0, 0, 32'h0,   7));
    // Same load-use with port 1 disabled: no stall.
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 7, 4, 0, 0,  1, 0, 0, 0, 32'h0,   7));
    vecs.push_back(mk(1, 2, 7, 2'b01, 0, 0, 1, 0, 0,  1, 0, 0, 0, 32'h80,  7));
    // WAW on x9: lat 4 then lat 1; stalls while cnt[9] > 1.
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 9, 4, 0, 0,  1, 0, 0, 0, 32'h80,  7));
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 9, 1, 0, 0,  0, 1, 0, 1, 32'h280, 7));
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 9, 1, 0, 0,  0, 1, 0, 1, 32'h280, 8));
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 9, 1, 0, 0,  0, 1, 0, 1, 32'h200, 9));
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 9, 1, 0, 0,  1, 0, 0, 0, 32'h200, 10));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0,  0, 0, 0, 0, 32'h200, 10));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0,  0, 0, 0, 0, 32'h0,   10));
    // x0 never tracked.
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 0, 4, 0, 0,  1, 0, 0, 0, 32'h0,   10));
    vecs.push_back(mk(1, 0, 0, 2'b11, 0, 0, 1, 0, 0,  1, 0, 0, 0, 32'h0,   10));
    // Flush over a live hazard: no stall, no issue, no count.
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 5, 2, 0, 0,  1, 0, 0, 0, 32'h0,   10));
    vecs.push_back(mk(1, 5, 0, 2'b01, 0, 0, 1, 1, 0,  0, 0, 0, 0, 32'h20,  10));
    vecs.push_back(mk(1, 5, 0, 2'b01, 0, 0, 1, 0, 0,  0, 1, 1, 0, 32'h20,  10));
    vecs.push_back(mk(1, 5, 0, 2'b01, 0, 0, 1, 0, 0,  1, 0, 0, 0, 32'h0,   11));
    // Clamp: lat 0 -> 1.
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 10, 0, 0, 0, 1, 0, 0, 0, 32'h0,   11));
    vecs.push_back(mk(1, 10, 0, 2'b01, 0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h400, 11));
    vecs.push_back(mk(1, 10, 0, 2'b01, 0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h0,   12));
    // Clamp: lat 7 -> 4.
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 11, 7, 0, 0, 1, 0, 0, 0, 32'h0,   12));
    vecs.push_back(mk(1, 11, 0, 2'b01, 0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h800, 12));
    vecs.push_back(mk(1, 11, 0, 2'b01, 0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h800, 13));
    vecs.push_back(mk(1, 11, 0, 2'b01, 0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h800, 14));
    vecs.push_back(mk(1, 11, 0, 2'b01, 0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h800, 15));
    vecs.push_back(mk(1, 11, 0, 2'b01, 0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h0,   16));
    // stat_clr.
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 1,  0, 0, 0, 0, 32'h0,   16));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0,  0, 0, 0, 0, 32'h0,   0));
    // WAW with equal pending count does not stall.
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 13, 3, 0, 0, 1, 0, 0, 0, 32'h0,    0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 13, 3, 0, 0, 1, 0, 0, 0, 32'h2000, 0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0,  0, 0, 0, 0, 32'h2000, 0));

    // Reset state, with a valid instruction present during reset.
    rst_n = 1'b0;
    drive(1, 0, 0, 2'b00, 0, 0, 1, 0, 0);
    #2;
    check("reset busy", 64'(busy), 64'h0);
    check("reset stall", 64'(stall), 64'h0);
    check("reset issue", 64'(issue), 64'h1);
    check("reset stall_cnt", 64'(stall_cnt), 64'h0);
    #10 rst_n = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 0);
    next_cycle();

    foreach (vecs[k]) begin
      drive(vecs[k].valid, vecs[k].rs0, vecs[k].rs1, vecs[k].re, vecs[k].we,
            vecs[k].rd, vecs[k].lat, vecs[k].fl, vecs[k].clr);
      #2;
      check($sformatf("v%0d issue", k),     64'(issue),     64'(vecs[k].e_issue));
      check($sformatf("v%0d stall", k),     64'(stall),     64'(vecs[k].e_stall));
      check($sformatf("v%0d stall_raw", k), 64'(stall_raw), 64'(vecs[k].e_raw));
      check($sformatf("v%0d stall_waw", k), 64'(stall_waw), 64'(vecs[k].e_waw));
      check($sformatf("v%0d busy", k),      64'(busy),      64'(vecs[k].e_busy));
      check($sformatf("v%0d stall_cnt", k), 64'(stall_cnt), 64'(vecs[k].e_scnt));
      next_cycle();
    end
    check("narrow cnt after clr", 64'(s_stall_cnt), 64'h0);

    // Saturation: 12 stall cycles; the 3-bit counter sticks at 7.
    nstall = 0;
    for (int rnd = 0; rnd < 3; rnd++) begin
      drive(1, 0, 0, 2'b00, 1, 12, 4, 0, 0);
      #2;
      check($sformatf("sat r%0d producer issue", rnd), 64'(issue), 64'h1);
      next_cycle();
      drive(1, 12, 0, 2'b01, 0, 0, 1, 0, 0);
      for (int j = 0; j < 4; j++) begin
        #2;
        check($sformatf("sat r%0d c%0d stall", rnd, j), 64'(s_stall), 64'h1);
        check($sformatf("sat r%0d c%0d cnt", rnd, j), 64'(s_stall_cnt),
              64'((nstall > 7) ? 7 : nstall));
        next_cycle();
        nstall++;
      end
      #2;
      check($sformatf("sat r%0d consumer issue", rnd), 64'(issue), 64'h1);
      next_cycle();
    end
    check("sat narrow cnt", 64'(s_stall_cnt), 64'h7);
    check("sat wide cnt", 64'(stall_cnt), 64'd12);
    drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 1);
    next_cycle();
    check("sat narrow after clr", 64'(s_stall_cnt), 64'h0);
    check("sat wide after clr", 64'(stall_cnt), 64'h0);

    // Async reset between edges while a dependent is stalled on x5.
    drive(1, 0, 0, 2'b00, 1, 5, 3, 0, 0);
    next_cycle();
    drive(1, 5, 0, 2'b01, 0, 0, 1, 0, 0);
    #2;
    check("arst pre stall", 64'(stall), 64'h1);
    check("arst pre busy", 64'(busy), 64'h20);
    #1 rst_n = 1'b0;
    #1;
    check("arst busy", 64'(busy), 64'h0);
    check("arst stall", 64'(stall), 64'h0);
    check("arst issue", 64'(issue), 64'h1);
    check("arst stall_cnt", 64'(stall_cnt), 64'h0);
    rst_n = 1'b1;
    #1;
    check("arst release issue", 64'(issue), 64'h1);
    check("arst release stall", 64'(stall), 64'h0);
    next_cycle();
    drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 0);
    #2;
    check("arst after busy", 64'(busy), 64'h0);
    check("arst after stall_cnt", 64'(stall_cnt), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
